// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream packet FIFO: default bus width,
// pointer-width helper and FSM state encoding.
package axis_pkg;

    localparam int AXIS_BUS_WIDTH = 32;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_DROP = 1'b1
    } pkt_state_e;

    // One extra pointer bit separates full from empty when the indices match.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Beat storage for the packet FIFO: one synchronous write port and one
// asynchronous read port, no reset (contents are don't-care until written).
module axis_fifo_mem #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             aclk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO: a packet is only presented on the
// master side once its tlast beat is stored; packets larger than DEPTH are dropped.
module axis_pkt_fifo
    import axis_pkg::*;
#(
    parameter int BUS_WIDTH = AXIS_BUS_WIDTH,
    parameter int DEPTH     = 16
) (
    input  logic                        aclk,
    input  logic                        ARESET,
    input  logic [BUS_WIDTH-1:0]        s_tdata,
    input  logic                        s_tvalid,
    input  logic                        s_tlast,
    output logic                        s_tready,
    output logic [BUS_WIDTH-1:0]        m_tdata,
    output logic                        m_tvalid,
    output logic                        m_tlast,
    input  logic                        m_tready,
    output logic [ptr_width(DEPTH)-1:0] pkt_count,
    output logic                        drop_pulse,
    output logic [15:0]                 drop_cnt
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    pkt_state_e state;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] pkt_start;
    logic [BUS_WIDTH:0] rd_word;
    logic full;
    logic s_xfer;
    logic m_xfer;
    logic wr_en;
    logic oversize;
    logic drop_done;
    logic pkt_inc;
    logic pkt_dec;

    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Full with no complete packet means the in-progress packet can never fit:
    // keep accepting so the oversize beat is swallowed instead of stalling the source.
    assign s_tready = (state == ST_DROP) || !full || (pkt_count == '0);
    assign m_tvalid = (pkt_count != '0);

    assign s_xfer   = s_tvalid && s_tready;
    assign m_xfer   = m_tvalid && m_tready;
    assign oversize = (state == ST_FILL) && full && (pkt_count == '0) && s_tvalid;
    assign wr_en    = (state == ST_FILL) && s_xfer && !full;
    assign pkt_inc  = wr_en && s_tlast;
    assign pkt_dec  = m_xfer && m_tlast;

    assign drop_done = ((state == ST_DROP) && s_xfer && s_tlast) || (oversize && s_tlast);

    assign m_tdata = rd_word[BUS_WIDTH-1:0];
    assign m_tlast = rd_word[BUS_WIDTH];

    axis_fifo_mem #(
        .WIDTH (BUS_WIDTH + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .aclk    (aclk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data ({s_tlast, s_tdata}),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_word)
    );

    always_ff @(posedge aclk or posedge ARESET) begin
        if (ARESET) begin
            state      <= ST_FILL;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pkt_start  <= '0;
            pkt_count  <= '0;
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            drop_pulse <= drop_done;
            if (drop_done && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end

            if (m_xfer) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            case ({pkt_inc, pkt_dec})
                2'b10:   pkt_count <= pkt_count + PTR_ONE;
                2'b01:   pkt_count <= pkt_count - PTR_ONE;
                default: ;
            endcase

            case (state)
                ST_FILL: begin
                    if (oversize) begin
                        // Rewind discards every stored beat of the oversize packet.
                        wr_ptr <= pkt_start;
                        if (!s_tlast) begin
                            state <= ST_DROP;
                        end
                    end else if (wr_en) begin
                        wr_ptr <= wr_ptr + PTR_ONE;
                        if (s_tlast) begin
                            pkt_start <= wr_ptr + PTR_ONE;
                        end
                    end
                end
                ST_DROP: begin
                    if (s_xfer && s_tlast) begin
                        state <= ST_FILL;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

endmodule
